bcd_to_7seg: RTL and testbench
==============================

BCD_TO_7SEG -- requirements
Module: bcd_to_7seg

Interface
REQ-001 Parameters: none; the block SHALL have no parameters.
REQ-002 clk  input  1  system clock, rising-edge; the block SHALL have exactly this one clock.
REQ-003 reset  input  1  reset; it SHALL be asynchronous and active-high.
REQ-004 bcd  input  4  BCD digit to display; 0-9 are valid, 10-15 are invalid.
REQ-005 seven_seg_display  output  7  segment enables, active-high (1 = segment lit).
REQ-006 Output bit mapping SHALL be: bit0 = A (top), bit1 = B (upper right), bit2 = C (lower right), bit3 = D (bottom), bit4 = E (lower left), bit5 = F (upper left), bit6 = G (middle).

Function
REQ-007 While reset is low, seven_seg_display SHALL be a purely combinational decode of bcd, with zero-cycle latency.
- The output SHALL settle within the same timestep as any bcd change.
- The output SHALL NOT depend on clk edges.
REQ-008 clk SHALL be present for interface compatibility only and SHALL NOT alter the decode result.
REQ-009 Decode table SHALL be:
- 0 -> 7'b0111111 (A B C D E F)
- 1 -> 7'b0000110 (B C)
- 2 -> 7'b1011011 (A B D E G)
- 3 -> 7'b1001111 (A B C D G)
- 4 -> 7'b1100110 (B C F G)
- 5 -> 7'b1101101 (A C D F G)
- 6 -> 7'b1111101 (A C D E F G)
- 7 -> 7'b0000111 (A B C)
- 8 -> 7'b1111111 (all segments)
- 9 -> 7'b1100111 (A B C F G)
REQ-010 Invalid codes 10-15 SHALL drive 7'b0000000 (display blank).
REQ-011 The decode SHALL be a full case with no latches; every input combination SHALL produce a defined output.
REQ-012 Consecutive bcd changes SHALL each be reflected immediately, with no glitch-holding or pipelining state.

Reset
REQ-013 While reset is high, seven_seg_display SHALL be 7'b0000000 regardless of bcd or clk.
REQ-014 On reset assertion, including mid-operation, the output SHALL go to 0 immediately (asynchronous, no clock edge required).
REQ-015 On reset deassertion, the output SHALL immediately show the decode of the current bcd, with no wait cycles.
REQ-016 The block SHALL contain no state, so the post-reset behaviour SHALL be identical to the pre-reset behaviour.

Verification
REQ-017 Hold reset=1 for 30 cycles with bcd=0 -> seven_seg_display=7'b0000000 throughout; release reset -> 7'b0111111 in the same timestep.
REQ-018 With reset=0, sweep bcd 0..9, one value per clock, and check one cycle later -> each output matches REQ-009 exactly (0 mismatches over 10 digits).
REQ-019 With reset=0, apply bcd 10..15 -> 7'b0000000 for each.
REQ-020 Set bcd=8, then assert reset between clock edges -> output drops from 7'b1111111 to 7'b0000000 without a clk edge; deassert -> 7'b1111111 returns.
REQ-021 Change bcd 1 -> 7 midway between clk edges -> output changes 7'b0000110 -> 7'b0000111 in the same timestep.
REQ-022 Hold bcd=5 for 20 cycles with clk toggling -> output stays at 7'b1101101 with no transitions.

Source files
------------

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-high seven-segment decoder (bit0 = A ... bit6 = G).
// Purely combinational; reset blanks the display asynchronously and clk is carried for interface compatibility only.
module bcd_to_7seg (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  output logic [6:0] seven_seg_display
);

  logic [6:0] seg_d;
  logic       unused_clk;

  // clk deliberately has no effect on the decode.
  assign unused_clk = clk;

  always_comb begin
    seg_d = 7'b0000000;
    unique case (bcd)
      4'd0:    seg_d = 7'b0111111;
      4'd1:    seg_d = 7'b0000110;
      4'd2:    seg_d = 7'b1011011;
      4'd3:    seg_d = 7'b1001111;
      4'd4:    seg_d = 7'b1100110;
      4'd5:    seg_d = 7'b1101101;
      4'd6:    seg_d = 7'b1111101;
      4'd7:    seg_d = 7'b0000111;
      4'd8:    seg_d = 7'b1111111;
      4'd9:    seg_d = 7'b1100111;
      default: seg_d = 7'b0000000;
    endcase
  end

  assign seven_seg_display = reset ? 7'b0000000 : seg_d;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Directed self-checking bench for bcd_to_7seg using immediate assertions.
module tb_bcd_to_7seg;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_tbl [0:9];

  bcd_to_7seg dut (
    .clk               (clk),
    .reset             (reset),
    .bcd               (bcd),
    .seven_seg_display (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] expected);
    n_checks++;
    assert (seg === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, seg, expected);
    end
  endtask

  initial begin
    exp_tbl[0] = 7'b0111111;
    exp_tbl[1] = 7'b0000110;
    exp_tbl[2] = 7'b1011011;
    exp_tbl[3] = 7'b1001111;
    exp_tbl[4] = 7'b1100110;
    exp_tbl[5] = 7'b1101101;
    exp_tbl[6] = 7'b1111101;
    exp_tbl[7] = 7'b0000111;
    exp_tbl[8] = 7'b1111111;
    exp_tbl[9] = 7'b1100111;

    reset = 1'b1;
    bcd   = 4'd0;

    // Reset held for 30 cycles: display blank throughout.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 check($sformatf("reset_hold_%0d", i), 7'b0000000);
    end

    // Release between edges; decode of 0 must appear with no clock edge.
    #2 reset = 1'b0;
    #1 check("reset_release", 7'b0111111);

    // Sweep valid digits, one per clock, checked one cycle later.
    for (int d = 0; d < 10; d++) begin
      @(posedge clk);
      #2 bcd = 4'(d);
      @(posedge clk);
      #1 check($sformatf("digit_%0d", d), exp_tbl[d]);
    end

    // Invalid codes blank the display.
    for (int d = 10; d < 16; d++) begin
      @(posedge clk);
      #2 bcd = 4'(d);
      #1 check($sformatf("invalid_%0d", d), 7'b0000000);
    end

    // Asynchronous reset mid-operation on digit 8.
    @(posedge clk);
    #2 bcd = 4'd8;
    #1 check("async_pre", 7'b1111111);
    #1 reset = 1'b1;
    #1 check("async_assert", 7'b0000000);
    #1 reset = 1'b0;
    #1 check("async_release", 7'b1111111);

    // Mid-cycle change 1 -> 7.
    @(posedge clk);
    #1 bcd = 4'd1;
    #1 check("mid_1", 7'b0000110);
    #2 bcd = 4'd7;
    #1 check("mid_7", 7'b0000111);

    // Hold 5 for 20 cycles with clk toggling; sample after both edges.
    @(posedge clk);
    #2 bcd = 4'd5;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 check($sformatf("hold5_pos_%0d", i), 7'b1101101);
      @(negedge clk);
      #1 check($sformatf("hold5_neg_%0d", i), 7'b1101101);
    end

    // Back-to-back digit changes between edges, no clock in between.
    @(posedge clk);
    #1 bcd = 4'd3;
    #1 check("b2b_3", 7'b1001111);
    bcd = 4'd6;
    #1 check("b2b_6", 7'b1111101);
    bcd = 4'd9;
    #1 check("b2b_9", 7'b1100111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
